// File: rtl/rv_pkg.sv
// Shared types for the rv_* array packers: FSM state encoding and the lane-index width helper.
package rv_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } pack_state_t;

    // A lane index never needs fewer than one bit, even for degenerate widths.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rv_arr_pack.sv
// Scalar-to-frame packer: collects N beats into a registered frame with ready/valid on both sides.
// Optional macro RV_ARR_PACK_FLUSH_EN adds s_last to close a frame early.
//
//   state   | meaning
//   --------+------------------------------------------------------
//   ST_FILL | collecting beats into lanes, s_ready high, m_count 0
//   ST_FULL | frame held for output, waits for gate_emit && m_ready
module rv_arr_pack
    import rv_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DW-1:0]            s_data,
`ifdef RV_ARR_PACK_FLUSH_EN
    input  logic                     s_last,
`endif
    input  logic                     gate_emit,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DW-1:0]            m_data [0:N-1],
    output logic [$clog2(N+1)-1:0]   m_count
);

    localparam int IW = idx_width(N);
    localparam int CW = $clog2(N+1);

    pack_state_t   r_state;
    pack_state_t   w_state_nxt;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_nxt;
    logic [DW-1:0] r_lane [0:N-1];
    logic [DW-1:0] w_lane_nxt [0:N-1];
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          w_in_hs;
    logic          w_out_hs;
    logic          w_close;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_count <= '0;
            for (int i = 0; i < N; i++) begin
                r_lane[i] <= '0;
            end
        end else begin
            r_idx   <= w_idx_nxt;
            r_count <= w_count_nxt;
            for (int i = 0; i < N; i++) begin
                r_lane[i] <= w_lane_nxt[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_count_nxt = r_count;
        for (int i = 0; i < N; i++) begin
            w_lane_nxt[i] = r_lane[i];
        end

        m_valid  = (r_state == ST_FULL) && gate_emit;
        w_out_hs = m_valid && m_ready;
        s_ready  = (r_state == ST_FILL) || w_out_hs;
        w_in_hs  = s_valid && s_ready;

        w_close = (r_idx == IW'(N-1));
`ifdef RV_ARR_PACK_FLUSH_EN
        w_close = w_close || s_last;
`endif

        case (r_state)
            ST_FILL: begin
                if (w_in_hs) begin
                    for (int i = 0; i < N; i++) begin
                        if (IW'(i) == r_idx) begin
                            w_lane_nxt[i] = s_data;
                        end
                    end
                    if (w_close) begin
                        w_state_nxt = ST_FULL;
                        w_count_nxt = CW'(r_idx) + CW'(1);
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end
            end
            ST_FULL: begin
                if (w_out_hs) begin
                    // Lanes are cleared here so that every FILL starts from zeros.
                    for (int i = 0; i < N; i++) begin
                        w_lane_nxt[i] = '0;
                    end
                    w_count_nxt = '0;
                    w_state_nxt = ST_FILL;
                    w_idx_nxt   = '0;
                    if (w_in_hs) begin
                        w_lane_nxt[0] = s_data;
`ifdef RV_ARR_PACK_FLUSH_EN
                        if (s_last) begin
                            w_state_nxt = ST_FULL;
                            w_count_nxt = CW'(1);
                        end else begin
                            w_idx_nxt = IW'(1);
                        end
`else
                        w_idx_nxt = IW'(1);
`endif
                    end
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
    end

    assign m_data  = r_lane;
    assign m_count = r_count;

endmodule

// File: tb/tb_rv_arr_pack.sv
// Directed self-checking bench for rv_arr_pack (N=4, DW=32); flush case needs RV_ARR_PACK_FLUSH_EN.
module tb_rv_arr_pack;

    localparam int N  = 4;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
`ifdef RV_ARR_PACK_FLUSH_EN
    logic          s_last;
`endif
    logic          gate_emit;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data [0:N-1];
    logic [2:0]    m_count;

    int n_tests;
    int n_fail;

    rv_arr_pack #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
`ifdef RV_ARR_PACK_FLUSH_EN
        .s_last    (s_last),
`endif
        .gate_emit (gate_emit),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_count   (m_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_frame(input string tag, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                             input logic [DW-1:0] e2, input logic [DW-1:0] e3, input logic [2:0] ecnt);
        chk({tag, "_lane0"}, 64'(m_data[0]), 64'(e0));
        chk({tag, "_lane1"}, 64'(m_data[1]), 64'(e1));
        chk({tag, "_lane2"}, 64'(m_data[2]), 64'(e2));
        chk({tag, "_lane3"}, 64'(m_data[3]), 64'(e3));
        chk({tag, "_count"}, 64'(m_count), 64'(ecnt));
    endtask

    task automatic send(input logic [DW-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        #1;
        chk("s_ready_fill", 64'(s_ready), 64'd1);
        cyc();
        s_valid = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
`ifdef RV_ARR_PACK_FLUSH_EN
        s_last    = 1'b0;
`endif
        gate_emit = 1'b1;
        m_ready   = 1'b1;

        // reset state
        cyc();
        cyc();
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        chk_frame("rst", 32'h0, 32'h0, 32'h0, 32'h0, 3'd0);
        rst_n = 1'b1;

        // basic frame
        send(32'h11);
        #1;
        chk("basic_no_early_valid", 64'(m_valid), 64'd0);
        send(32'h22);
        send(32'h33);
        send(32'h44);
        #1;
        chk("basic_m_valid", 64'(m_valid), 64'd1);
        chk_frame("basic", 32'h11, 32'h22, 32'h33, 32'h44, 3'd4);
        cyc();
        chk("basic_after_hs_valid", 64'(m_valid), 64'd0);
        chk_frame("basic_after_hs", 32'h0, 32'h0, 32'h0, 32'h0, 3'd0);

        // 8 continuous beats, no bubble
        for (int i = 1; i <= 8; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(i);
            #1;
            chk("stream_s_ready", 64'(s_ready), 64'd1);
            if (i == 5) begin
                chk("stream_f1_valid", 64'(m_valid), 64'd1);
                chk_frame("stream_f1", 32'd1, 32'd2, 32'd3, 32'd4, 3'd4);
            end
            cyc();
            if (i == 5) begin
                chk("stream_b5_valid", 64'(m_valid), 64'd0);
                chk_frame("stream_b5", 32'd5, 32'd0, 32'd0, 32'd0, 3'd0);
            end
        end
        s_valid = 1'b0;
        #1;
        chk("stream_f2_valid", 64'(m_valid), 64'd1);
        chk_frame("stream_f2", 32'd5, 32'd6, 32'd7, 32'd8, 3'd4);
        cyc();

        // gate_emit withholding
        send(32'hA1);
        send(32'hA2);
        send(32'hA3);
        gate_emit = 1'b0;
        send(32'hA4);
        s_valid = 1'b1;
        s_data  = 32'hEE;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("gate_m_valid", 64'(m_valid), 64'd0);
            chk("gate_s_ready", 64'(s_ready), 64'd0);
            chk_frame("gate_hold", 32'hA1, 32'hA2, 32'hA3, 32'hA4, 3'd4);
            cyc();
        end
        s_valid   = 1'b0;
        gate_emit = 1'b1;
        #1;
        chk("gate_release_valid", 64'(m_valid), 64'd1);
        chk_frame("gate_release", 32'hA1, 32'hA2, 32'hA3, 32'hA4, 3'd4);
        cyc();
        chk("gate_after_hs_valid", 64'(m_valid), 64'd0);
        chk_frame("gate_after_hs", 32'h0, 32'h0, 32'h0, 32'h0, 3'd0);

        // m_ready backpressure with pending input
        m_ready = 1'b0;
        send(32'hB1);
        send(32'hB2);
        send(32'hB3);
        send(32'hB4);
        s_valid = 1'b1;
        s_data  = 32'hC1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_s_ready", 64'(s_ready), 64'd0);
            chk("bp_m_valid", 64'(m_valid), 64'd1);
            chk_frame("bp_hold", 32'hB1, 32'hB2, 32'hB3, 32'hB4, 3'd4);
            cyc();
        end
        m_ready = 1'b1;
        #1;
        chk("bp_release_s_ready", 64'(s_ready), 64'd1);
        cyc();
        s_valid = 1'b0;
        chk("bp_after_valid", 64'(m_valid), 64'd0);
        chk_frame("bp_after", 32'hC1, 32'h0, 32'h0, 32'h0, 3'd0);
        send(32'hC2);
        send(32'hC3);
        send(32'hC4);
        #1;
        chk_frame("bp_next", 32'hC1, 32'hC2, 32'hC3, 32'hC4, 3'd4);
        cyc();

        // reset mid-frame, beat during reset discarded
        send(32'hD1);
        send(32'hD2);
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h99;
        cyc();
        s_valid = 1'b0;
        rst_n   = 1'b1;
        chk("midrst_m_valid", 64'(m_valid), 64'd0);
        chk_frame("midrst", 32'h0, 32'h0, 32'h0, 32'h0, 3'd0);
        send(32'hE1);
        send(32'hE2);
        send(32'hE3);
        send(32'hE4);
        #1;
        chk("postrst_valid", 64'(m_valid), 64'd1);
        chk_frame("postrst", 32'hE1, 32'hE2, 32'hE3, 32'hE4, 3'd4);

        // reset while FULL discards held frame
        m_ready = 1'b0;
        rst_n   = 1'b0;
        cyc();
        rst_n   = 1'b1;
        m_ready = 1'b1;
        #1;
        chk("fullrst_m_valid", 64'(m_valid), 64'd0);
        chk_frame("fullrst", 32'h0, 32'h0, 32'h0, 32'h0, 3'd0);

`ifdef RV_ARR_PACK_FLUSH_EN
        // early close with s_last
        send(32'hA);
        s_last = 1'b1;
        send(32'hB);
        s_last = 1'b0;
        #1;
        chk("flush_m_valid", 64'(m_valid), 64'd1);
        chk_frame("flush", 32'hA, 32'hB, 32'h0, 32'h0, 3'd2);
        cyc();
        chk("flush_after_valid", 64'(m_valid), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_arr_pack.md
RV_ARR_PACK -- requirements
Module: rv_arr_pack

Interface
REQ-001 SHALL have parameter N, default 4, number of lanes per output frame (N>=2).
REQ-002 SHALL have parameter DW, default 32, bits per lane.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port s_valid  input  1  input beat valid.
REQ-006 SHALL have port s_ready  output  1  input beat accepted when s_valid && s_ready.
REQ-007 SHALL have port s_data  input  DW  scalar input beat.
REQ-008 SHALL have port gate_emit  input  1  output permission; frame is withheld while low.
REQ-009 SHALL have port m_valid  output  1  output frame valid.
REQ-010 SHALL have port m_ready  input  1  downstream accept.
REQ-011 SHALL have port m_data  output  unpacked array [0:N-1] of DW  assembled frame, lane 0 = first beat.
REQ-012 SHALL have port m_count  output  $clog2(N+1)  number of populated lanes in the presented frame.

Function
REQ-013 SHALL implement two states: FILL (collecting beats) and FULL (frame held for output).
REQ-014 In FILL, s_ready SHALL be 1; each accepted beat SHALL write s_data to lane idx and increment idx.
REQ-015 Accepting a beat at idx==N-1 SHALL transition to FULL, set m_count=N, and reset idx to 0.
REQ-016 m_valid SHALL equal (state==FULL) && gate_emit; it SHALL assert the cycle after the completing beat (latency 1 cycle).
REQ-017 In FULL, s_ready SHALL equal m_valid && m_ready (combinational path m_ready->s_ready permitted).
REQ-018 An output handshake with no simultaneous input beat SHALL return to FILL with idx=0 and clear all lanes to zero.
REQ-019 An output handshake with a simultaneous input beat SHALL write that beat into lane 0, clear lanes 1..N-1, set idx=1, state FILL; no beat lost, no bubble (sustained N beats per N cycles).
REQ-020 While FULL and gate_emit or m_ready is low, m_data and m_count SHALL remain stable and s_ready SHALL be 0.
REQ-021 gate_emit deasserting while FULL SHALL drop m_valid without changing the held frame.
REQ-022 m_data SHALL always be driven from registers (no s_data-to-m_data combinational path).
REQ-023 In FILL, m_count SHALL read 0.

Reset
REQ-024 When rst_n is low at a clock edge: state=FILL, idx=0, all m_data lanes=0, m_count=0, m_valid=0.
REQ-025 s_ready SHALL be 1 during reset assertion only via FILL-state decode; beats presented during reset are discarded.
REQ-026 Reset mid-frame or while FULL SHALL discard the partial/held frame with no output handshake.

Configuration
REQ-027 Macro RV_ARR_PACK_FLUSH_EN SHALL, when defined, add port s_last  input  1  closes the current frame early.
REQ-028 With RV_ARR_PACK_FLUSH_EN, an accepted beat with s_last=1 at idx=k SHALL go FULL with m_count=k+1 and lanes k+1..N-1 zero; s_last at idx=N-1 is equivalent to a normal complete frame.
REQ-029 Without RV_ARR_PACK_FLUSH_EN, s_last SHALL not exist and m_count SHALL be N in every FULL frame.

Structure
REQ-030 Shared package rv_pkg SHALL hold the FILL/FULL state enum typedef and the lane-index width helper ($clog2-based); module-local logic SHALL not redefine them.
REQ-031 Single flat module; no sub-module (idx counter and lane registers are inline).

Verification
REQ-032 N=4,DW=32, gate_emit=1, m_ready=1: beats 0x11,0x22,0x33,0x44 back-to-back -> one cycle later m_valid=1, m_data={0x11,0x22,0x33,0x44}, m_count=4.
REQ-033 8 continuous beats 1..8 with m_ready=1 -> frames {1,2,3,4},{5,6,7,8}; s_ready never 0 after first frame; beat 5 lands in lane 0 in the handshake cycle.
REQ-034 Frame complete, gate_emit=0 for 5 cycles -> m_valid=0, s_ready=0, m_data unchanged; gate_emit=1 -> m_valid=1 next evaluation, handshake completes.
REQ-035 Frame complete, m_ready=0 for 3 cycles with s_valid=1 -> no input accepted, data stable; m_ready=1 -> handshake plus beat into lane 0 same cycle.
REQ-036 Two beats accepted then rst_n=0 one cycle -> m_valid=0, m_count=0, lanes zero; next 4 beats form a clean frame.
REQ-037 With RV_ARR_PACK_FLUSH_EN: beats 0xA,0xB with s_last on 0xB -> m_data={0xA,0xB,0,0}, m_count=2.
